// File: rtl/decode_stage.sv
// Registered instruction-decode stage with load scoreboard and valid/ready handshake.
// Optional statistics counters are enabled with `define DECODE_STAGE_STATS_EN.
module decode_stage #(
  parameter int INST_W  = 16,
  parameter int OP_W    = 4,
  parameter int REG_W   = 3,
  parameter int FUNCT_W = 3,
  parameter int IMM_W   = 6,
  parameter int DATA_W  = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [INST_W-1:0]  INST,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  input  logic               FLUSH,
  input  logic               WB_VALID,
  input  logic [REG_W-1:0]   WB_ADDR,
  output logic [REG_W-1:0]   RS_ADDR,
  output logic [REG_W-1:0]   RT_ADDR,
  output logic [REG_W-1:0]   WR_ADDR,
  output logic               WR_EN,
  output logic [FUNCT_W-1:0] ALU_FUNC,
  output logic               ALU_SRC_IMM,
  output logic [DATA_W-1:0]  IMM_EXT,
  output logic               MEM_RD,
  output logic               MEM_WR,
  output logic [1:0]         BR_COND,
  output logic               BRANCH,
  output logic               ILLEGAL
`ifdef DECODE_STAGE_STATS_EN
  ,
  output logic [15:0]        INST_CNT,
  output logic [15:0]        STALL_CNT
`endif
);

  localparam int NREG   = 1 << REG_W;
  localparam int RS_LSB = INST_W - OP_W - REG_W;
  localparam int RT_LSB = RS_LSB - REG_W;
  localparam int RD_LSB = RT_LSB - REG_W;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(4'd0);
  localparam logic [OP_W-1:0] OP_LB   = OP_W'(4'd2);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(4'd4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4'd5);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(4'd6);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(4'd7);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'd8);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4'd9);
  localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(4'd10);
  localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(4'd11);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(3'd0);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(3'd5);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(3'd6);

  logic [OP_W-1:0]    op_s;
  logic [REG_W-1:0]   rs_s, rt_s, rd_s;
  logic [FUNCT_W-1:0] funct_s;
  logic [IMM_W-1:0]   imm_s;
  logic [DATA_W-1:0]  sext_s, zext_s;

  assign op_s    = INST[INST_W-1 -: OP_W];
  assign rs_s    = INST[RS_LSB +: REG_W];
  assign rt_s    = INST[RT_LSB +: REG_W];
  assign rd_s    = INST[RD_LSB +: REG_W];
  assign funct_s = INST[FUNCT_W-1:0];
  assign imm_s   = INST[IMM_W-1:0];
  assign sext_s  = DATA_W'($signed(imm_s));
  assign zext_s  = DATA_W'(imm_s);

  logic [REG_W-1:0]   dec_wr_addr_s;
  logic               dec_we_raw_s, dec_we_s, dec_src_s, dec_mrd_s, dec_mwr_s;
  logic               dec_br_s, dec_ill_s, reads_rt_s;
  logic [FUNCT_W-1:0] dec_func_s;
  logic [DATA_W-1:0]  dec_imm_s;
  logic [1:0]         dec_brc_s;

  // Opcode decode into the control bundle for the instruction presented by fetch
  always_comb begin
    dec_wr_addr_s = '0;
    dec_we_raw_s  = 1'b0;
    dec_func_s    = FN_ADD;
    dec_src_s     = 1'b0;
    dec_imm_s     = '0;
    dec_mrd_s     = 1'b0;
    dec_mwr_s     = 1'b0;
    dec_brc_s     = 2'b00;
    dec_br_s      = 1'b0;
    dec_ill_s     = 1'b0;
    reads_rt_s    = 1'b0;
    case (op_s)
      OP_R: begin
        dec_we_raw_s  = 1'b1;
        dec_wr_addr_s = rd_s;
        dec_func_s    = funct_s;
        reads_rt_s    = 1'b1;
      end
      OP_LB: begin
        dec_mrd_s     = 1'b1;
        dec_we_raw_s  = 1'b1;
        dec_wr_addr_s = rt_s;
        dec_src_s     = 1'b1;
        dec_imm_s     = sext_s;
      end
      OP_SB: begin
        dec_mwr_s  = 1'b1;
        dec_src_s  = 1'b1;
        dec_imm_s  = sext_s;
        reads_rt_s = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_we_raw_s  = 1'b1;
        dec_wr_addr_s = rt_s;
        dec_src_s     = 1'b1;
        dec_func_s    = (op_s == OP_ADDI) ? FN_ADD : ((op_s == OP_ANDI) ? FN_AND : FN_OR);
        dec_imm_s     = (op_s == OP_ADDI) ? sext_s : zext_s;
      end
      OP_BEQ, OP_BNE, OP_BGEZ, OP_BLTZ: begin
        dec_br_s   = 1'b1;
        dec_brc_s  = op_s[1:0];
        dec_imm_s  = sext_s;
        reads_rt_s = 1'b1;
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
  end

  // Writes to register 0 are architecturally discarded
  assign dec_we_s = dec_we_raw_s & (dec_wr_addr_s != '0);

  logic              valid_q, valid_d;
  logic [NREG-1:0]   busy_q, busy_d, set_mask_s, clr_mask_s;
  logic              hazard_s, accept_s, handoff_s;
  logic [REG_W-1:0]  rs_q, rt_q, wr_addr_q;
  logic              wr_en_q, src_q, mrd_q, mwr_q, br_q, ill_q;
  logic [FUNCT_W-1:0] func_q;
  logic [DATA_W-1:0] imm_q;
  logic [1:0]        brc_q;

  assign hazard_s  = busy_q[rs_s] | (reads_rt_s & busy_q[rt_s]);
  assign IN_READY  = RESET_N & (~valid_q | OUT_READY) & ~hazard_s & ~FLUSH;
  assign accept_s  = IN_VALID & IN_READY;
  assign handoff_s = valid_q & OUT_READY;

  // A load leaving for execute marks its destination busy; set beats a same-cycle writeback clear
  assign set_mask_s = (handoff_s & mrd_q) ? (NREG'(1'b1) << wr_addr_q) : '0;
  assign clr_mask_s = WB_VALID ? (NREG'(1'b1) << WB_ADDR) : '0;
  assign busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NREG'(1'b1);

  // Output-valid next state: accept, else drop on flush or handoff, else hold
  always_comb begin
    valid_d = valid_q;
    if (accept_s) begin
      valid_d = 1'b1;
    end else if (FLUSH || OUT_READY) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output bundle and scoreboard registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      valid_q   <= 1'b0;
      busy_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      func_q    <= '0;
      src_q     <= 1'b0;
      imm_q     <= '0;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      brc_q     <= 2'b00;
      br_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      if (accept_s) begin
        rs_q      <= rs_s;
        rt_q      <= rt_s;
        wr_addr_q <= dec_wr_addr_s;
        wr_en_q   <= dec_we_s;
        func_q    <= dec_func_s;
        src_q     <= dec_src_s;
        imm_q     <= dec_imm_s;
        mrd_q     <= dec_mrd_s;
        mwr_q     <= dec_mwr_s;
        brc_q     <= dec_brc_s;
        br_q      <= dec_br_s;
        ill_q     <= dec_ill_s;
      end
    end
  end

  assign OUT_VALID   = valid_q;
  assign RS_ADDR     = rs_q;
  assign RT_ADDR     = rt_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_EN       = wr_en_q;
  assign ALU_FUNC    = func_q;
  assign ALU_SRC_IMM = src_q;
  assign IMM_EXT     = imm_q;
  assign MEM_RD      = mrd_q;
  assign MEM_WR      = mwr_q;
  assign BR_COND     = brc_q;
  assign BRANCH      = br_q;
  assign ILLEGAL     = ill_q;

`ifdef DECODE_STAGE_STATS_EN
  logic [15:0] inst_cnt_q, stall_cnt_q;

  // Saturating accepted-instruction and hazard-stall counters
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      inst_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (accept_s && (inst_cnt_q != 16'hFFFF)) inst_cnt_q <= inst_cnt_q + 16'd1;
      if (IN_VALID && hazard_s && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign INST_CNT  = inst_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RESET_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY, FLUSH, WB_VALID;
  logic [15:0] INST;
  logic [2:0]  WB_ADDR, RS_ADDR, RT_ADDR, WR_ADDR, ALU_FUNC;
  logic        WR_EN, ALU_SRC_IMM, MEM_RD, MEM_WR, BRANCH, ILLEGAL;
  logic [15:0] IMM_EXT;
  logic [1:0]  BR_COND;
`ifdef DECODE_STAGE_STATS_EN
  logic [15:0] INST_CNT, STALL_CNT;
`endif

  decode_stage dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INST(INST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLUSH(FLUSH), .WB_VALID(WB_VALID),
    .WB_ADDR(WB_ADDR), .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR), .WR_ADDR(WR_ADDR), .WR_EN(WR_EN),
    .ALU_FUNC(ALU_FUNC), .ALU_SRC_IMM(ALU_SRC_IMM), .IMM_EXT(IMM_EXT), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .BR_COND(BR_COND), .BRANCH(BRANCH), .ILLEGAL(ILLEGAL)
`ifdef DECODE_STAGE_STATS_EN
    , .INST_CNT(INST_CNT), .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  logic [36:0] dut_bundle;
  assign dut_bundle = {OUT_VALID, RS_ADDR, RT_ADDR, WR_ADDR, WR_EN, ALU_FUNC, ALU_SRC_IMM,
                       IMM_EXT, MEM_RD, MEM_WR, BR_COND, BRANCH, ILLEGAL};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid = 1'b0;
  logic [35:0] m_bundle = '0;
  logic [7:0]  m_busy = '0;
  logic        m_ld = 1'b0;
  int          m_dst = 0;
  int          m_inst_cnt = 0;
  int          m_stall_cnt = 0;
  logic        exp_ready, obs_ready;

  function automatic int fld(input logic [15:0] w, input int lsb, input int width);
    return (int'(w) >> lsb) & ((1 << width) - 1);
  endfunction

  function automatic bit reads_rt(input int op);
    return (op == 0) || (op == 4) || (op >= 8 && op <= 11);
  endfunction

  function automatic logic [35:0] ref_decode(input logic [15:0] w);
    int op, rs, rt, rd, fn, imm, sext;
    int wr, we, af, asrc, ext, mr, mw, bc, br, ill;
    op = fld(w, 12, 4); rs = fld(w, 9, 3); rt = fld(w, 6, 3); rd = fld(w, 3, 3);
    fn = fld(w, 0, 3);  imm = fld(w, 0, 6);
    sext = (imm >= 32) ? (imm + 65536 - 64) : imm;
    wr = 0; we = 0; af = 0; asrc = 0; ext = 0; mr = 0; mw = 0; bc = 0; br = 0; ill = 0;
    case (op)
      0:            begin we = 1; wr = rd; af = fn; end
      2:            begin mr = 1; we = 1; wr = rt; asrc = 1; ext = sext; end
      4:            begin mw = 1; asrc = 1; ext = sext; end
      5:            begin we = 1; wr = rt; asrc = 1; ext = sext; end
      6:            begin we = 1; wr = rt; asrc = 1; af = 5; ext = imm; end
      7:            begin we = 1; wr = rt; asrc = 1; af = 6; ext = imm; end
      8, 9, 10, 11: begin br = 1; bc = op - 8; ext = sext; end
      default:      ill = 1;
    endcase
    if (wr == 0) we = 0;
    return {3'(rs), 3'(rt), 3'(wr), 1'(we), 3'(af), 1'(asrc), 16'(ext),
            1'(mr), 1'(mw), 2'(bc), 1'(br), 1'(ill)};
  endfunction

  function automatic bit ref_hazard(input logic [15:0] w);
    return m_busy[fld(w, 9, 3)] || (reads_rt(fld(w, 12, 4)) && m_busy[fld(w, 6, 3)]);
  endfunction

  // One clock: sample IN_READY mid-cycle, advance the model at the edge, settle outputs
  task automatic tick();
    logic [7:0] nb;
    @(negedge CLK);
    exp_ready = RESET_N && (!m_valid || OUT_READY) && !ref_hazard(INST) && !FLUSH;
    obs_ready = IN_READY;
    @(posedge CLK);
    if (!RESET_N) begin
      m_valid = 1'b0; m_bundle = '0; m_busy = '0; m_ld = 1'b0; m_dst = 0;
      m_inst_cnt = 0; m_stall_cnt = 0;
    end else begin
      nb = m_busy;
      if (WB_VALID) nb[WB_ADDR] = 1'b0;
      if (m_valid && OUT_READY && m_ld && m_dst != 0) nb[m_dst] = 1'b1;
      if (IN_VALID && ref_hazard(INST) && m_stall_cnt < 65535) m_stall_cnt++;
      if (IN_VALID && exp_ready) begin
        m_bundle = ref_decode(INST);
        m_valid  = 1'b1;
        m_ld     = (fld(INST, 12, 4) == 2);
        m_dst    = fld(INST, 6, 3);
        if (m_inst_cnt < 65535) m_inst_cnt++;
      end else if (FLUSH || OUT_READY) begin
        m_valid = 1'b0;
      end
      m_busy = nb;
    end
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; IN_VALID = 1'b1; INST = 16'h0298; OUT_READY = 1'b1;
    FLUSH = 1'b0; WB_VALID = 1'b0; WB_ADDR = 3'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_ready: got %b expected 0", obs_ready);
      end
      n_checks++;
      if (dut_bundle !== 37'd0) begin
        n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_bundle);
      end
    end
    RESET_N = 1'b1; IN_VALID = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", obs_ready);
    end
  endtask

  task automatic test_decode();
    logic [15:0] tbl [11] = '{16'h0298, 16'h52BF, 16'h72BF, 16'h62BF, 16'h4A85, 16'h9A45,
                              16'hF000, 16'h0040, 16'hB03F, 16'h3000, 16'h1FFF};
    for (int i = 0; i < 11; i++) begin
      IN_VALID = 1'b1; INST = tbl[i]; OUT_READY = 1'b1;
      tick();
      n_checks++;
      if (obs_ready !== exp_ready || dut_bundle !== {m_valid, m_bundle}) begin
        n_fail++;
        $display("FAIL decode_%h: got rdy=%b %h expected rdy=%b %h",
                 tbl[i], obs_ready, dut_bundle, exp_ready, {m_valid, m_bundle});
      end
      case (i)
        0: begin
          n_checks++;
          if ({RS_ADDR, RT_ADDR, WR_ADDR, WR_EN, ALU_FUNC, ALU_SRC_IMM} !==
              {3'd1, 3'd2, 3'd3, 1'b1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL add_fields: got %b %b %b %b %b %b expected 1 2 3 1 0 0",
                               RS_ADDR, RT_ADDR, WR_ADDR, WR_EN, ALU_FUNC, ALU_SRC_IMM);
          end
        end
        1: begin
          n_checks++;
          if ({WR_ADDR, ALU_SRC_IMM, IMM_EXT} !== {3'd2, 1'b1, 16'hFFFF}) begin
            n_fail++; $display("FAIL addi_fields: got wr=%0d src=%b imm=%h expected 2 1 ffff",
                               WR_ADDR, ALU_SRC_IMM, IMM_EXT);
          end
        end
        2: begin
          n_checks++;
          if (IMM_EXT !== 16'h003F) begin
            n_fail++; $display("FAIL ori_imm: got %h expected 003f", IMM_EXT);
          end
        end
        6: begin
          n_checks++;
          if ({ILLEGAL, WR_EN, MEM_RD, MEM_WR, BRANCH} !== 5'b10000) begin
            n_fail++; $display("FAIL illegal_flags: got %b expected 10000",
                               {ILLEGAL, WR_EN, MEM_RD, MEM_WR, BRANCH});
          end
        end
        7: begin
          n_checks++;
          if (WR_EN !== 1'b0) begin
            n_fail++; $display("FAIL r0_wr_en: got %b expected 0", WR_EN);
          end
        end
        default: ;
      endcase
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_load_hazard();
    int base;
    IN_VALID = 1'b1; INST = 16'h2300; OUT_READY = 1'b1;
    tick();
    n_checks++;
    if ({OUT_VALID, MEM_RD, WR_ADDR} !== {1'b1, 1'b1, 3'd4}) begin
      n_fail++; $display("FAIL lb_decode: got v=%b rd=%b wr=%0d expected 1 1 4",
                         OUT_VALID, MEM_RD, WR_ADDR);
    end
    IN_VALID = 1'b0;
    tick();
    base = m_stall_cnt;
    IN_VALID = 1'b1; INST = 16'h0868;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs_ready !== 1'b0 || exp_ready !== 1'b0) begin
        n_fail++; $display("FAIL hazard_stall_%0d: got %b expected 0", i, obs_ready);
      end
    end
    WB_VALID = 1'b1; WB_ADDR = 3'd4;
    tick();
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL hazard_wb_cycle: got %b expected 0", obs_ready);
    end
    WB_VALID = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1 || OUT_VALID !== 1'b1 || WR_ADDR !== 3'd5) begin
      n_fail++; $display("FAIL hazard_release: got rdy=%b v=%b wr=%0d expected 1 1 5",
                         obs_ready, OUT_VALID, WR_ADDR);
    end
`ifdef DECODE_STAGE_STATS_EN
    n_checks++;
    if (int'(STALL_CNT) - base !== 5) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected 5", int'(STALL_CNT) - base);
    end
`endif
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [36:0] held;
    IN_VALID = 1'b1; INST = 16'h0298; OUT_READY = 1'b1;
    tick();
    held = {m_valid, m_bundle};
    OUT_READY = 1'b0; INST = 16'h52BF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_bundle !== held || obs_ready !== 1'b0) begin
        n_fail++; $display("FAIL backpressure_%0d: got rdy=%b %h expected rdy=0 %h",
                           i, obs_ready, dut_bundle, held);
      end
    end
    FLUSH = 1'b1;
    tick();
    n_checks++;
    if (obs_ready !== 1'b0 || OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL flush: got rdy=%b v=%b expected 0 0", obs_ready, OUT_VALID);
    end
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
  endtask

  task automatic test_flush_handoff();
    IN_VALID = 1'b1; INST = 16'h2300; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0; FLUSH = 1'b1; WB_VALID = 1'b1; WB_ADDR = 3'd4;
    tick();
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL flush_handoff_valid: got %b expected 0", OUT_VALID);
    end
    FLUSH = 1'b0; WB_VALID = 1'b0; IN_VALID = 1'b1; INST = 16'h0868;
    tick();
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL set_wins_busy: got %b expected 0", obs_ready);
    end
    WB_VALID = 1'b1;
    tick();
    WB_VALID = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL set_wins_release: got %b expected 1", obs_ready);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstall();
    IN_VALID = 1'b1; INST = 16'h2300; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    IN_VALID = 1'b1; INST = 16'h0868;
    tick();
    RESET_N = 1'b0;
    tick();
    n_checks++;
    if (obs_ready !== 1'b0 || dut_bundle !== 37'd0) begin
      n_fail++; $display("FAIL midstall_reset: got rdy=%b %h expected 0 0", obs_ready, dut_bundle);
    end
    RESET_N = 1'b1;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL midstall_release: got rdy=%b v=%b expected 1 1", obs_ready, OUT_VALID);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int ops [16] = '{0, 2, 2, 4, 5, 6, 7, 8, 9, 10, 11, 2, 0, 3, 15, 12};
    for (int i = 0; i < 600; i++) begin
      RESET_N   = ($urandom_range(0, 99) != 0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      INST      = 16'(ops[$urandom_range(0, 15)] << 12) | 16'($urandom_range(0, 4095));
      OUT_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 9) == 0);
      WB_VALID  = ($urandom_range(0, 2) == 0);
      WB_ADDR   = 3'($urandom_range(0, 7));
      tick();
      n_checks++;
      if (obs_ready !== exp_ready || dut_bundle !== {m_valid, m_bundle}) begin
        n_fail++;
        $display("FAIL random_%0d: got rdy=%b %h expected rdy=%b %h",
                 i, obs_ready, dut_bundle, exp_ready, {m_valid, m_bundle});
      end
    end
`ifdef DECODE_STAGE_STATS_EN
    n_checks++;
    if (int'(INST_CNT) !== m_inst_cnt || int'(STALL_CNT) !== m_stall_cnt) begin
      n_fail++; $display("FAIL random_stats: got %0d %0d expected %0d %0d",
                         INST_CNT, STALL_CNT, m_inst_cnt, m_stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_hazard();
    test_backpressure();
    test_flush_handoff();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage for the 16-bit datapath; sits between fetch and execute.
- Splits the instruction word into fields, generates control signals and sign/zero-extends the immediate.
- Holds the result in an output register with a valid/ready handshake.
- Keeps a per-register load scoreboard and stalls any instruction that reads a register with a load still outstanding.

Parameters:
- INST_W, 16, instruction width; must equal OP_W + 3*REG_W + FUNCT_W.
- OP_W, 4, opcode field width (top bits of INST).
- REG_W, 3, register-address width; there are 2**REG_W registers.
- FUNCT_W, 3, R-type function field width (low bits).
- IMM_W, 6, immediate field width (low bits, I-type).
- DATA_W, 16, width of extended immediate; must be >= IMM_W.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous reset, active-low.
- IN_VALID  in  1  fetch presents an instruction.
- IN_READY  out  1  stage accepts the instruction this cycle.
- INST  in  INST_W  instruction word.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  execute accepts the bundle.
- FLUSH  in  1  kill the held bundle (branch taken).
- WB_VALID  in  1  a load writeback completes this cycle.
- WB_ADDR  in  REG_W  destination register of that writeback.
- RS_ADDR, RT_ADDR  out  REG_W  source register addresses.
- WR_ADDR  out  REG_W  destination register address.
- WR_EN  out  1  register write enable.
- ALU_FUNC  out  FUNCT_W  ALU operation.
- ALU_SRC_IMM  out  1  operand B is IMM_EXT.
- IMM_EXT  out  DATA_W  extended immediate.
- MEM_RD, MEM_WR  out  1  load / store.
- BR_COND  out  2  branch condition: 0=EQ, 1=NE, 2=GEZ, 3=LTZ.
- BRANCH  out  1  instruction is a branch.
- ILLEGAL  out  1  opcode is undefined.

Behaviour:
- Field positions: OP=INST[15:12], RS=[11:9], RT=[8:6], RD=[5:3], FUNCT=[2:0], IMM=[5:0]. The generalised positions are the same layout packed from the MSB down.
- Opcodes and the control signals they set:
  - 0000 R-type: WR_EN=1, WR_ADDR=RD, ALU_FUNC=FUNCT.
  - 0010 LB: MEM_RD, WR_EN, WR_ADDR=RT, ALU_SRC_IMM, ALU_FUNC=ADD(000), IMM sign-extended.
  - 0100 SB: MEM_WR, ALU_SRC_IMM, ALU_FUNC=ADD, IMM sign-extended.
  - 0101 ADDI: WR_EN, WR_ADDR=RT, ALU_FUNC=000, IMM sign-extended.
  - 0110 ANDI: as ADDI but ALU_FUNC=101, IMM zero-extended.
  - 0111 ORI: as ADDI but ALU_FUNC=110, IMM zero-extended.
  - 1000/1001/1010/1011: BRANCH=1, BR_COND=OP[1:0], IMM sign-extended.
  - Any other opcode: ILLEGAL=1, all enables 0.
- WR_EN is forced to 0 whenever the destination register is register 0.
- Output register loads when IN_VALID && IN_READY. Latency: 1 cycle from acceptance to OUT_VALID.
- Handshake:
  - IN_READY = (!OUT_VALID || OUT_READY) && !hazard && !FLUSH.
  - OUT_VALID is set on acceptance and cleared when OUT_READY is high without a new acceptance.
  - While OUT_VALID && !OUT_READY, every output holds stable.
- Hazard: busy[RS] is set, or the instruction reads RT (R-type, SB, branch) and busy[RT] is set. Register 0 is never busy. No data forwarding is done.
- Scoreboard:
  - busy[WR_ADDR] is set when a MEM_RD bundle hands off (OUT_VALID && OUT_READY).
  - busy[WB_ADDR] is cleared on WB_VALID.
  - Set and clear of the same register in the same cycle: set wins.
  - A WB_VALID to a register that is not busy is ignored.
- FLUSH: OUT_VALID is cleared next cycle and no instruction is accepted that cycle. The scoreboard is unchanged. If FLUSH coincides with a handoff, the handoff completes first; its scoreboard update happens, then OUT_VALID clears.
- Reset (RESET_N low at the clock edge, including mid-stall):
  - OUT_VALID=0 and all busy bits cleared.
  - All decoded outputs = 0; ILLEGAL=0.
  - IN_READY = 0 during reset.

Optional Feature:
- Macro: DECODE_STAGE_STATS_EN.
- Defined: adds 16-bit output ports INST_CNT and STALL_CNT, both saturating at 0xFFFF and cleared by reset.
  - INST_CNT increments per accepted instruction.
  - STALL_CNT increments each cycle IN_VALID=1 and IN_READY=0 because of hazard.
- Undefined: no such ports and no counter logic.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles -> OUT_VALID=0, IN_READY=0, all outputs 0; release -> IN_READY=1.
- INST=0x0298 (ADD R3,R1,R2), OUT_READY=1 -> next cycle RS_ADDR=1, RT_ADDR=2, WR_ADDR=3, WR_EN=1, ALU_FUNC=0, ALU_SRC_IMM=0.
- INST=0x52BF (ADDI R2,R1,-1) -> WR_ADDR=2, ALU_SRC_IMM=1, IMM_EXT=0xFFFF. INST=0x72BF (ORI) -> IMM_EXT=0x003F.
- INST=0x2300 (LB R4) handed off, then 0x0868 (ADD R5,R4,R1):
  - IN_READY=0 until WB_VALID=1 with WB_ADDR=4.
  - Accepted the cycle after; STALL_CNT equals the stall cycles when DECODE_STAGE_STATS_EN is defined.
- Backpressure: OUT_READY=0 for 3 cycles with IN_VALID=1 -> outputs stable, IN_READY=0; assert FLUSH -> OUT_VALID=0 next cycle.
- INST=0xF000 -> ILLEGAL=1, WR_EN=MEM_RD=MEM_WR=BRANCH=0. INST=0x0040 (writes R0) -> WR_EN=0.
